// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: accepts one SLL/SRL/SRA request, shifts one bit per cycle,
// then presents a registered result with a one-cycle done pulse.
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= OpSll;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = operand;
          cnt_d   = shamt;
          op_d    = op;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          // Reserved op leaves acc untouched so the result echoes the operand.
          case (op_q)
            OpSll:   acc_d = {acc_q[30:0], 1'b0};
            OpSrl:   acc_d = {1'b0, acc_q[31:1]};
            OpSra:   acc_d = {acc_q[31], acc_q[31:1]};
            default: acc_d = acc_q;
          endcase
        end else begin
          result_d = acc_q;
          err_d    = (op_q == OpRsv);
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q == StShift) || (state_q == StDone);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign err    = err_q;

endmodule
